// File: rtl/regfile_issue.sv
// Operand-issue and write-back stage of the POCO 16-bit datapath.
// Holds the register file, the EX operand register and the ALU result write-back.
module regfile_issue #(
  parameter int NREG = 8,
  parameter int W    = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [2:0]    in_com,
  input  logic          in_use_imm,
  input  logic [W-1:0]  in_imm,
  input  logic          in_we,
  input  logic          hold,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_com,
  input  logic [W-1:0]  alu_y,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [W-1:0]  wb_data,
  output logic [15:0]   retire_cnt,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0]  regs [NREG];
  logic          ex_valid;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [2:0]    ex_com;
  logic [AW-1:0] ex_rd;
  logic          ex_we;

  logic          fwd;
  logic          xfer;
  logic [W-1:0]  a_src;
  logic [W-1:0]  b_src;

  assign in_ready = ~hold;
  assign xfer     = in_valid & in_ready;

  // EX result lands on the same edge that samples the next operands
  assign fwd = ex_valid & ex_we;

  always_comb begin
    a_src = regs[in_rd];
    if (fwd && ex_rd == in_rd)
      a_src = alu_y;
    b_src = in_use_imm ? in_imm : regs[in_rs];
    if (fwd && ex_rd == in_rs && !in_use_imm)
      b_src = alu_y;
  end

  assign wb_valid = ex_valid & ex_we & ~hold;
  assign wb_addr  = ex_rd;
  assign wb_data  = alu_y;

  assign alu_a    = ex_a;
  assign alu_b    = ex_b;
  assign alu_com  = ex_com;
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_com     <= 3'b000;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      retire_cnt <= 16'h0000;
    end else begin
      if (wb_valid) begin
        regs[ex_rd] <= alu_y;
        retire_cnt  <= retire_cnt + 16'd1;
      end
      if (!hold) begin
        ex_valid <= in_valid;
        if (xfer) begin
          ex_a   <= a_src;
          ex_b   <= b_src;
          ex_com <= in_com;
          ex_rd  <= in_rd;
          ex_we  <= in_we;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: per-cycle vector table plus
// retire counter wrap and mid-operation reset sequences.
module tb_regfile_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_com;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        in_we;
  logic        hold;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_com;
  logic [15:0] alu_y;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] retire_cnt;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int failures = 0;

  regfile_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_com     (in_com),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_we      (in_we),
    .hold       (hold),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_com    (alu_com),
    .alu_y      (alu_y),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .retire_cnt (retire_cnt),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 001 pass b, 110 add, 010 sub, others xor
  always_comb begin
    unique case (alu_com)
      3'b001:  alu_y = alu_b;
      3'b110:  alu_y = alu_a + alu_b;
      3'b010:  alu_y = alu_a - alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic        v;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  com;
    logic        ui;
    logic [15:0] imm;
    logic        we;
    logic        hold;
    logic [2:0]  dbg;
    logic        rdy;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  acom;
    logic        wbv;
    logic [2:0]  wba;
    logic [15:0] y;
    logic [15:0] ret;
    logic [15:0] dbgd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] com,
                       input logic ui, input logic [15:0] imm,
                       input logic we, input logic h,
                       input logic [2:0] dbg);
    in_valid   = v;
    in_rd      = rd;
    in_rs      = rs;
    in_com     = com;
    in_use_imm = ui;
    in_imm     = imm;
    in_we      = we;
    hold       = h;
    dbg_addr   = dbg;
  endtask

  initial begin
    vecs[0]  = '{0,0,0,3'b000,0,16'h0000,0,0,0, 1,16'h0000,16'h0000,3'b000,0,0,16'h0000,16'h0000,16'h0000};
    vecs[1]  = '{0,0,0,3'b000,0,16'h0000,0,0,7, 1,16'h0000,16'h0000,3'b000,0,0,16'h0000,16'h0000,16'h0000};
    vecs[2]  = '{1,1,0,3'b001,1,16'h1234,1,0,1, 1,16'h0000,16'h0000,3'b000,0,0,16'h0000,16'h0000,16'h0000};
    vecs[3]  = '{1,1,1,3'b001,1,16'h0005,1,0,1, 1,16'h0000,16'h1234,3'b001,1,1,16'h1234,16'h0000,16'h0000};
    vecs[4]  = '{1,1,1,3'b110,0,16'h0000,1,0,1, 1,16'h1234,16'h0005,3'b001,1,1,16'h0005,16'h0001,16'h1234};
    vecs[5]  = '{1,2,0,3'b001,1,16'h0100,1,0,1, 1,16'h0005,16'h0005,3'b110,1,1,16'h000A,16'h0002,16'h0005};
    vecs[6]  = '{1,4,0,3'b001,1,16'hBEEF,1,1,2, 0,16'h0000,16'h0100,3'b001,0,2,16'h0100,16'h0003,16'h0000};
    vecs[7]  = '{1,4,0,3'b001,1,16'hBEEF,1,1,2, 0,16'h0000,16'h0100,3'b001,0,2,16'h0100,16'h0003,16'h0000};
    vecs[8]  = '{1,4,0,3'b001,1,16'hBEEF,1,1,2, 0,16'h0000,16'h0100,3'b001,0,2,16'h0100,16'h0003,16'h0000};
    vecs[9]  = '{0,0,0,3'b000,0,16'h0000,0,0,2, 1,16'h0000,16'h0100,3'b001,1,2,16'h0100,16'h0003,16'h0000};
    vecs[10] = '{0,0,0,3'b000,0,16'h0000,0,0,2, 1,16'h0000,16'h0100,3'b001,0,2,16'h0100,16'h0004,16'h0100};
    vecs[11] = '{1,3,1,3'b010,0,16'h0000,0,0,4, 1,16'h0000,16'h0100,3'b001,0,2,16'h0100,16'h0004,16'h0000};
    vecs[12] = '{1,5,3,3'b110,0,16'h0000,1,0,3, 1,16'h0000,16'h000A,3'b010,0,3,16'hFFF6,16'h0004,16'h0000};
    vecs[13] = '{0,0,0,3'b000,0,16'h0000,0,0,3, 1,16'h0000,16'h0000,3'b110,1,5,16'h0000,16'h0004,16'h0000};
    vecs[14] = '{0,0,0,3'b000,0,16'h0000,0,0,4, 1,16'h0000,16'h0000,3'b110,0,5,16'h0000,16'h0005,16'h0000};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].rs, vecs[i].com, vecs[i].ui,
            vecs[i].imm, vecs[i].we, vecs[i].hold, vecs[i].dbg);
      #1;
      chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d alu_com", i), 16'(alu_com), 16'(vecs[i].acom));
      chk($sformatf("v%0d wb_valid", i), 16'(wb_valid), 16'(vecs[i].wbv));
      if (vecs[i].wbv) begin
        chk($sformatf("v%0d wb_addr", i), 16'(wb_addr), 16'(vecs[i].wba));
        chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].y);
      end
      chk($sformatf("v%0d retire_cnt", i), retire_cnt, vecs[i].ret);
      chk($sformatf("v%0d dbg_data", i), dbg_data, vecs[i].dbgd);
      @(negedge clk);
    end

    // Retire counter wrap: 5 retired so far, 65530 more reach 0xFFFF
    for (int i = 0; i < 65530; i++) begin
      drive(1, 7, 0, 3'b001, 1, 16'(i), 1, 0, 7);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    @(negedge clk);
    #1;
    chk("wrap pre retire_cnt", retire_cnt, 16'hFFFF);
    chk("wrap r7 last data", dbg_data, 16'(65529));
    @(negedge clk);
    drive(1, 7, 0, 3'b001, 1, 16'hCAFE, 1, 0, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
    @(negedge clk);
    #1;
    chk("wrap post retire_cnt", retire_cnt, 16'h0000);
    chk("wrap r7 data", dbg_data, 16'hCAFE);

    // Reset while an EX write is pending
    @(negedge clk);
    drive(1, 6, 0, 3'b001, 1, 16'h7777, 1, 0, 6);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 6);
    rst = 1'b1;
    #1;
    chk("rst pending wb_valid", 16'(wb_valid), 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst r6 not written", dbg_data, 16'h0000);
    chk("rst retire_cnt", retire_cnt, 16'h0000);
    chk("rst alu_a", alu_a, 16'h0000);
    chk("rst alu_b", alu_b, 16'h0000);
    chk("rst alu_com", 16'(alu_com), 16'h0000);
    chk("rst wb_valid", 16'(wb_valid), 16'h0000);
    dbg_addr = 3'd7;
    #1;
    chk("rst r7 cleared", dbg_data, 16'h0000);
    @(negedge clk);
    #1;
    chk("rst idle retire_cnt", retire_cnt, 16'h0000);
    chk("rst idle r6", dbg_data, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
